// File: rtl/result_drain_pkg.sv
// Shared types and sizing helpers for the result drain block.
//   drain_state_t : serialiser FSM states
//   elem_idx_w()  : width of a tile element index, never below one bit
package result_drain_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } drain_state_t;

    // Default array geometry; instances with other N1/N2 size themselves
    // through elem_idx_w().
    localparam int DEF_N1     = 4;
    localparam int DEF_N2     = 4;
    localparam int TILE_ELEMS = DEF_N1 * DEF_N2;

    function automatic int elem_idx_w(input int elems);
        return (elems > 1) ? $clog2(elems) : 1;
    endfunction

    localparam int ELEM_W = elem_idx_w(TILE_ELEMS);

endpackage

// File: rtl/drain_addr_gen.sv
// Tile position tracking and result-memory address generation.
//   tile_adv   : a tile completed (accepted or dropped); step tc/tr/base
//   tile_start : the completing tile is accepted; latch its base
//   e_sel      : element index to address (0 when tile_start)
//   addr       : base + i*M3 + j for e_sel (combinational)
//   tile_cnt   : tiles seen since reset
module drain_addr_gen #(
    parameter int N1           = 4,
    parameter int N2           = 4,
    parameter int MATRIXSIZE_W = 16,
    parameter int ADDR_W_C     = 12,
    parameter int EW           = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [MATRIXSIZE_W-1:0] M1dN1,
    input  logic [MATRIXSIZE_W-1:0] M3dN2,
    input  logic                    tile_adv,
    input  logic                    tile_start,
    input  logic [EW-1:0]           e_sel,
    output logic [ADDR_W_C-1:0]     addr,
    output logic [MATRIXSIZE_W-1:0] tile_cnt
);

    localparam logic [MATRIXSIZE_W-1:0] ONE = MATRIXSIZE_W'(1);

    logic [MATRIXSIZE_W-1:0] tc;
    logic [MATRIXSIZE_W-1:0] tr;
    logic [ADDR_W_C-1:0]     m3;
    logic [ADDR_W_C-1:0]     row_step;
    logic [ADDR_W_C-1:0]     row_base;
    logic [ADDR_W_C-1:0]     base_next;
    logic [ADDR_W_C-1:0]     cur_base;
    logic [ADDR_W_C-1:0]     base_sel;
    int unsigned             e_int;
    int unsigned             i_idx;
    int unsigned             j_idx;

    assign m3       = ADDR_W_C'(M3dN2) * ADDR_W_C'(N2);
    assign row_step = m3 * ADDR_W_C'(N1);

    // base_next always points at the tile that will complete next, so a
    // dropped tile still moves later tiles to their proper place.
    always_ff @(posedge clk) begin
        if (rst) begin
            tc        <= '0;
            tr        <= '0;
            row_base  <= '0;
            base_next <= '0;
            cur_base  <= '0;
            tile_cnt  <= '0;
        end else begin
            if (tile_start)
                cur_base <= base_next;
            if (tile_adv) begin
                tile_cnt <= tile_cnt + ONE;
                if (tc == M3dN2 - ONE) begin
                    tc <= '0;
                    if (tr == M1dN1 - ONE) begin
                        tr        <= '0;
                        row_base  <= '0;
                        base_next <= '0;
                    end else begin
                        tr        <= tr + ONE;
                        row_base  <= row_base + row_step;
                        base_next <= row_base + row_step;
                    end
                end else begin
                    tc        <= tc + ONE;
                    base_next <= base_next + ADDR_W_C'(N2);
                end
            end
        end
    end

    always_comb begin
        base_sel = tile_start ? base_next : cur_base;
        e_int    = 32'(e_sel);
        i_idx    = e_int / N2;
        j_idx    = e_int % N2;
        addr     = base_sel + ADDR_W_C'(i_idx) * m3 + ADDR_W_C'(j_idx);
    end

endmodule

// File: rtl/result_drain.sv
// Captures finished PE tile sums along the diagonal wavefront, double-buffers
// the completed tile and writes it, one element per cycle, into result
// memory C (row-major).
//   clk, rst              : clock, synchronous active-high reset
//   M1dN1, M3dN2          : row / column tile counts
//   M1xM3dN1xN2           : total tiles to write
//   init[i][j], acc[i][j] : per-PE completion strobe and result
//   wr_en/wr_addr/wr_data : result memory write port (registered)
//   busy                  : serialiser writing
//   done                  : all tiles written (sticky)
//   overflow              : a tile was dropped (sticky)
module result_drain
    import result_drain_pkg::*;
#(
    parameter int N1           = 4,
    parameter int N2           = 4,
    parameter int MATRIXSIZE_W = 16,
    parameter int ACC_W        = 32,
    parameter int ADDR_W_C     = 12
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [MATRIXSIZE_W-1:0] M1dN1,
    input  logic [MATRIXSIZE_W-1:0] M3dN2,
    input  logic [MATRIXSIZE_W-1:0] M1xM3dN1xN2,
    input  logic [N2-1:0]           init [N1-1:0],
    input  logic [ACC_W-1:0]        acc  [N1-1:0][N2-1:0],
    output logic                    wr_en,
    output logic [ADDR_W_C-1:0]     wr_addr,
    output logic [ACC_W-1:0]        wr_data,
    output logic                    busy,
    output logic                    done,
    output logic                    overflow
);

    localparam int             TE     = N1 * N2;
    localparam int             EW     = elem_idx_w(TE);
    localparam logic [EW-1:0]  LAST_E = EW'(TE - 1);
    localparam logic [EW-1:0]  E_ONE  = EW'(1);

    drain_state_t            state;
    drain_state_t            state_nxt;
    logic [EW-1:0]           e_cur;
    logic [EW-1:0]           e_nxt;
    logic [ACC_W-1:0]        cap      [TE];
    logic [ACC_W-1:0]        shadow   [TE];
    logic [ACC_W-1:0]        tile_src [TE];
    logic                    tc_evt;
    logic                    last_el;
    logic                    tiles_done;
    logic                    accept;
    logic                    drop;
    logic                    tile_adv;
    logic [MATRIXSIZE_W-1:0] tile_cnt;
    logic [ADDR_W_C-1:0]     gen_addr;
    logic                    wr_en_nxt;
    logic                    busy_nxt;
    logic                    done_nxt;
    logic                    overflow_nxt;
    logic [ADDR_W_C-1:0]     wr_addr_nxt;
    logic [ACC_W-1:0]        wr_data_nxt;

    // Capture and shadow buffers, one register per element. The last
    // element arrives in the tile-complete cycle, so it bypasses cap.
    for (genvar gi = 0; gi < N1; gi++) begin : g_row
        for (genvar gj = 0; gj < N2; gj++) begin : g_col
            localparam int K = gi * N2 + gj;

            always_ff @(posedge clk) begin
                if (init[gi][gj])
                    cap[K] <= acc[gi][gj];
            end

            if (K == TE - 1) begin : g_last
                assign tile_src[K] = acc[gi][gj];
            end else begin : g_body
                assign tile_src[K] = cap[K];
            end

            always_ff @(posedge clk) begin
                if (accept)
                    shadow[K] <= tile_src[K];
            end
        end
    end

    assign tc_evt     = init[N1-1][N2-1];
    assign last_el    = (state == WRITE) && (e_cur == LAST_E);
    assign tiles_done = (tile_cnt == M1xM3dN1xN2);
    assign accept     = tc_evt && ((state == IDLE) || (last_el && !tiles_done));
    assign drop       = tc_evt && (state == WRITE) && !last_el;
    assign tile_adv   = tc_evt && (state != DONE);

    drain_addr_gen #(
        .N1          (N1),
        .N2          (N2),
        .MATRIXSIZE_W(MATRIXSIZE_W),
        .ADDR_W_C    (ADDR_W_C),
        .EW          (EW)
    ) u_addr_gen (
        .clk       (clk),
        .rst       (rst),
        .M1dN1     (M1dN1),
        .M3dN2     (M3dN2),
        .tile_adv  (tile_adv),
        .tile_start(accept),
        .e_sel     (e_nxt),
        .addr      (gen_addr),
        .tile_cnt  (tile_cnt)
    );

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            e_cur    <= '0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state    <= state_nxt;
            e_cur    <= e_nxt;
            wr_en    <= wr_en_nxt;
            wr_addr  <= wr_addr_nxt;
            wr_data  <= wr_data_nxt;
            busy     <= busy_nxt;
            done     <= done_nxt;
            overflow <= overflow_nxt;
        end
    end

    // Next state; e_nxt is the element that will be on the port next cycle
    always_comb begin
        state_nxt = state;
        e_nxt     = e_cur;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = WRITE;
                    e_nxt     = '0;
                end
            end
            WRITE: begin
                if (!last_el)
                    e_nxt = e_cur + E_ONE;
                else if (accept)
                    e_nxt = '0;
                else if (tiles_done)
                    state_nxt = DONE;
                else
                    state_nxt = IDLE;
            end
            DONE:    state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    // Element 0 of a newly accepted tile is read from the capture side
    // because the shadow only loads on the same edge.
    always_comb begin
        wr_en_nxt    = (state_nxt == WRITE);
        busy_nxt     = wr_en_nxt;
        done_nxt     = (state_nxt == DONE);
        overflow_nxt = overflow | drop;
        wr_addr_nxt  = wr_addr;
        wr_data_nxt  = wr_data;
        if (wr_en_nxt) begin
            wr_addr_nxt = gen_addr;
            wr_data_nxt = accept ? tile_src[0] : shadow[e_nxt];
        end
    end

endmodule

// File: tb/tb_result_drain.sv
module tb_result_drain;

    localparam int N1 = 2;
    localparam int N2 = 2;
    localparam int MW = 16;
    localparam int AW = 32;
    localparam int CW = 12;

    logic          clk = 1'b0;
    logic          rst;
    logic [MW-1:0] M1dN1;
    logic [MW-1:0] M3dN2;
    logic [MW-1:0] M1xM3dN1xN2;
    logic [N2-1:0] init [N1-1:0];
    logic [AW-1:0] acc  [N1-1:0][N2-1:0];
    logic          wr_en;
    logic [CW-1:0] wr_addr;
    logic [AW-1:0] wr_data;
    logic          busy;
    logic          done;
    logic          overflow;

    always #5 clk = ~clk;

    result_drain #(
        .N1          (N1),
        .N2          (N2),
        .MATRIXSIZE_W(MW),
        .ACC_W       (AW),
        .ADDR_W_C    (CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .M1dN1      (M1dN1),
        .M3dN2      (M3dN2),
        .M1xM3dN1xN2(M1xM3dN1xN2),
        .init       (init),
        .acc        (acc),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .busy       (busy),
        .done       (done),
        .overflow   (overflow)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // wavefront schedule: start cycle of init[0][0] and data id per tile
    int sched_start[$];
    int sched_id[$];
    int rst_cyc;

    // observed and expected writes (cycle, addr, data)
    int wl_c[$], wl_a[$], wl_d[$];
    int ew_c[$], ew_a[$], ew_d[$];
    int done_first, ovf_first, done_drop, busy_bad;

    // address offset of element e inside a tile when M3 = 4
    int OFS [4] = '{0, 1, 4, 5};

    typedef struct {
        string name;
        int    m2;
        int    ntiles;
        int    ncyc;
        int    nacc;
        int    acc_tc   [4];
        int    acc_base [4];
        int    acc_id   [4];
        int    done_cyc;
        int    ovf_cyc;
    } vec_t;

    vec_t vecs [4];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        for (int i = 0; i < N1; i++) begin
            init[i] = '0;
            for (int j = 0; j < N2; j++)
                acc[i][j] = '0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic drive(input int c);
        rst = (c == rst_cyc);
        for (int i = 0; i < N1; i++) begin
            init[i] = '0;
            for (int j = 0; j < N2; j++) begin
                acc[i][j] = 32'hDEAD_0000 + 32'(c);
                for (int s = 0; s < sched_start.size(); s++) begin
                    if (c - sched_start[s] == i + j) begin
                        init[i]   = init[i] | N2'(1 << j);
                        acc[i][j] = 32'(10 * sched_id[s] + i * N2 + j + 1);
                    end
                end
            end
        end
    endtask

    task automatic run(input int ncyc);
        wl_c.delete(); wl_a.delete(); wl_d.delete();
        done_first = -1;
        ovf_first  = -1;
        done_drop  = 0;
        busy_bad   = 0;
        for (int c = 0; c < ncyc; c++) begin
            if (wr_en) begin
                wl_c.push_back(c);
                wl_a.push_back(int'(wr_addr));
                wl_d.push_back(int'(wr_data));
            end
            if (done && done_first < 0) done_first = c;
            if (!done && done_first >= 0) done_drop++;
            if (overflow && ovf_first < 0) ovf_first = c;
            if (busy !== wr_en) busy_bad++;
            drive(c);
            tick();
        end
        rst = 1'b0;
        idle_inputs();
    endtask

    task automatic clear_expect();
        ew_c.delete(); ew_a.delete(); ew_d.delete();
    endtask

    task automatic expect_tile(input int tc, input int base, input int id, input int nel);
        for (int e = 0; e < nel; e++) begin
            ew_c.push_back(tc + 1 + e);
            ew_a.push_back(base + OFS[e]);
            ew_d.push_back(10 * id + e + 1);
        end
    endtask

    task automatic compare_run(input string tag, input int exp_done, input int exp_ovf);
        chk({tag, " write_count"}, wl_c.size(), ew_c.size());
        for (int k = 0; k < ew_c.size() && k < wl_c.size(); k++) begin
            chk($sformatf("%s w%0d cycle", tag, k), wl_c[k], ew_c[k]);
            chk($sformatf("%s w%0d addr", tag, k), wl_a[k], ew_a[k]);
            chk($sformatf("%s w%0d data", tag, k), wl_d[k], ew_d[k]);
        end
        chk({tag, " done_cycle"}, done_first, exp_done);
        chk({tag, " done_sticky"}, done_drop, 0);
        chk({tag, " overflow_cycle"}, ovf_first, exp_ovf);
        chk({tag, " busy_vs_wr_en"}, busy_bad, 0);
    endtask

    initial begin
        vecs[0] = '{"single", 8, 1, 12, 1, '{3, 0, 0, 0},   '{0, 0, 0, 0},  '{0, 0, 0, 0}, -1, -1};
        vecs[1] = '{"b2b",    4, 4, 24, 4, '{3, 7, 11, 15}, '{0, 2, 8, 10}, '{0, 1, 2, 3}, 20, -1};
        vecs[2] = '{"drop",   3, 4, 20, 2, '{3, 9, 0, 0},   '{0, 8, 0, 0},  '{0, 2, 0, 0}, 14,  7};
        vecs[3] = '{"full",   8, 4, 36, 4, '{3, 11, 19, 27},'{0, 2, 8, 10}, '{0, 1, 2, 3}, 32, -1};

        M1dN1       = 16'd2;
        M3dN2       = 16'd2;
        M1xM3dN1xN2 = 16'd4;
        rst_cyc     = -1;
        do_reset();

        chk("reset wr_en",    int'(wr_en),    0);
        chk("reset wr_addr",  int'(wr_addr),  0);
        chk("reset wr_data",  int'(wr_data),  0);
        chk("reset busy",     int'(busy),     0);
        chk("reset done",     int'(done),     0);
        chk("reset overflow", int'(overflow), 0);

        // "full" runs last so the DONE state carries into the next sequence
        foreach (vecs[v]) begin
            do_reset();
            sched_start.delete();
            sched_id.delete();
            for (int k = 0; k < vecs[v].ntiles; k++) begin
                sched_start.push_back(1 + k * vecs[v].m2);
                sched_id.push_back(k);
            end
            rst_cyc = -1;
            run(vecs[v].ncyc);
            clear_expect();
            for (int a = 0; a < vecs[v].nacc; a++)
                expect_tile(vecs[v].acc_tc[a], vecs[v].acc_base[a], vecs[v].acc_id[a], 4);
            compare_run(vecs[v].name, vecs[v].done_cyc, vecs[v].ovf_cyc);
        end

        // wavefront after done: nothing written, flags unchanged
        sched_start.delete();
        sched_id.delete();
        sched_start.push_back(1);
        sched_id.push_back(5);
        rst_cyc = -1;
        run(10);
        clear_expect();
        compare_run("after_done", 0, -1);

        // reset while element 2 of tile 0 is on the port
        do_reset();
        sched_start.delete();
        sched_id.delete();
        sched_start.push_back(1);
        sched_id.push_back(0);
        sched_start.push_back(10);
        sched_id.push_back(1);
        rst_cyc = 6;
        run(20);
        clear_expect();
        expect_tile(3, 0, 0, 3);
        expect_tile(12, 0, 1, 4);
        compare_run("rst_mid", -1, -1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
